// File: rtl/wb_arbiter_2_wdt.sv
// ============================================================================
// wb_arbiter_2_wdt
// ----------------------------------------------------------------------------
// Two-master Wishbone arbiter with a grant FSM and an optional bus watchdog.
// One Wishbone slave port is shared between master 0 and master 1. A master's
// CYC is its bus request. Once a master is granted, it keeps the grant for the
// whole of its CYC. There is no preemption.
//
// Arbitration (registered, one cycle of latency from request to wbs_cyc_o):
//   ARB_TYPE_ROUND_ROBIN = 1 : on a tie, the master not granted last wins.
//                              After reset the preferred master wins the
//                              first tie.
//   ARB_TYPE_ROUND_ROBIN = 0 : fixed priority. On a tie, master 0 wins if
//                              ARB_LSB_HIGH_PRIORITY = 1, otherwise master 1.
// Between two grants there is always one idle cycle with wbs_cyc_o = 0.
//
// Optional feature, macro WB_ARB_WATCHDOG_EN:
//   When defined, a 16-bit counter measures how long a strobe goes
//   unanswered. After TIMEOUT such cycles the access is aborted:
//     - the granted master gets a one-cycle err_o,
//     - timeout_o pulses for one cycle,
//     - the slave side is released.
//   The arbiter then waits for that master to drop CYC.
//   When not defined, there is no counter and timeout_o is tied to 0. A
//   stalled slave then holds the grant for as long as the master holds CYC.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   wbm0_* / wbm1_*     master-side Wishbone ports
//                       (adr/dat/we/sel/stb/cyc in, dat/ack/err/rty out)
//   wbs_*               slave-side Wishbone port
//                       (muxed request out, response in)
//   grant_o             one-hot grant; 2'b00 while idle or aborting
//   timeout_o           one-cycle pulse when the watchdog aborts an access
// ============================================================================
module wb_arbiter_2_wdt #(
  parameter int DATA_WIDTH            = 32,
  parameter int ADDR_WIDTH            = 32,
  parameter int SELECT_WIDTH          = DATA_WIDTH / 8,
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1,
  parameter int TIMEOUT               = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,
  input  logic                    wbm0_cyc_i,

  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,
  input  logic                    wbm1_cyc_i,

  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,

  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

  // Reset value of the round-robin pointer. The pointer records the master
  // granted last, so it starts at the *other* master. That way the preferred
  // master wins the first tie after reset.
  localparam logic LAST_RESET = (ARB_LSB_HIGH_PRIORITY != 0) ? 1'b1 : 1'b0;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;   // index of the granted (or aborting) master
  logic       last_q,  last_d;    // round-robin pointer: master granted last
  logic       busy;
  logic       winner;
  logic       slave_term;
  logic       wdt_expire;
  logic       abort_pulse;

  logic [ADDR_WIDTH-1:0]   own_adr;
  logic [DATA_WIDTH-1:0]   own_dat;
  logic [SELECT_WIDTH-1:0] own_sel;
  logic                    own_we;
  logic                    own_stb;
  logic                    own_cyc;

  assign busy       = (state_q == ST_BUSY);
  assign slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // --------------------------------------------------------------------------
  // Request mux for the current owner.
  // owner_q stays valid in ABORT, so the FSM can watch the owner's CYC there.
  // --------------------------------------------------------------------------
  always_comb begin
    if (owner_q) begin
      own_adr = wbm1_adr_i;
      own_dat = wbm1_dat_i;
      own_sel = wbm1_sel_i;
      own_we  = wbm1_we_i;
      own_stb = wbm1_stb_i;
      own_cyc = wbm1_cyc_i;
    end else begin
      own_adr = wbm0_adr_i;
      own_dat = wbm0_dat_i;
      own_sel = wbm0_sel_i;
      own_we  = wbm0_we_i;
      own_stb = wbm0_stb_i;
      own_cyc = wbm0_cyc_i;
    end
  end

  // Slave side: only driven while BUSY. It stays quiet in IDLE and in ABORT.
  // wbs_cyc_o follows the state rather than the owner's CYC. This keeps
  // exactly one dead cycle between consecutive grants.
  assign wbs_adr_o = busy ? own_adr : '0;
  assign wbs_dat_o = busy ? own_dat : '0;
  assign wbs_sel_o = busy ? own_sel : '0;
  assign wbs_we_o  = busy & own_we;
  assign wbs_stb_o = busy & own_stb;
  assign wbs_cyc_o = busy;

  // --------------------------------------------------------------------------
  // Response routing: only the granted master sees slave terminations.
  // --------------------------------------------------------------------------
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;

  assign wbm0_ack_o = busy & ~owner_q & wbs_ack_i;
  assign wbm0_rty_o = busy & ~owner_q & wbs_rty_i;
  assign wbm0_err_o = (busy & ~owner_q & wbs_err_i) | (abort_pulse & ~owner_q);

  assign wbm1_ack_o = busy & owner_q & wbs_ack_i;
  assign wbm1_rty_o = busy & owner_q & wbs_rty_i;
  assign wbm1_err_o = (busy & owner_q & wbs_err_i) | (abort_pulse & owner_q);

  assign grant_o   = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign timeout_o = abort_pulse;

  // --------------------------------------------------------------------------
  // Arbitration decision (only used in IDLE)
  // --------------------------------------------------------------------------
  always_comb begin
    winner = 1'b0;
    if (wbm0_cyc_i && wbm1_cyc_i) begin
      if (ARB_TYPE_ROUND_ROBIN != 0) begin
        winner = ~last_q;
      end else begin
        winner = (ARB_LSB_HIGH_PRIORITY != 0) ? 1'b0 : 1'b1;
      end
    end else begin
      winner = wbm1_cyc_i;
    end
  end

  // --------------------------------------------------------------------------
  // Grant FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (wbm0_cyc_i || wbm1_cyc_i) begin
          state_d = ST_BUSY;
          owner_d = winner;
        end
      end
      ST_BUSY: begin
        // Owner ending its cycle takes precedence over a watchdog expiry in
        // the same cycle: the master has already abandoned the access.
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (wdt_expire) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bus watchdog
  // --------------------------------------------------------------------------
`ifdef WB_ARB_WATCHDOG_EN
  localparam logic [15:0] WDT_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] wdt_cnt_q;
  logic        abort_pulse_q;

  // The counter holds the number of stalled cycles already elapsed. When it
  // equals TIMEOUT-1 in a stalled cycle, that cycle is the TIMEOUT-th
  // stalled one. A slave termination in that cycle still completes normally.
  assign wdt_expire = busy && wbs_stb_o && !slave_term && (wdt_cnt_q == WDT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_cnt_q     <= '0;
      abort_pulse_q <= 1'b0;
    end else begin
      if (busy && (state_d == ST_BUSY) && wbs_stb_o && !slave_term) begin
        wdt_cnt_q <= wdt_cnt_q + 16'd1;
      end else begin
        wdt_cnt_q <= '0;
      end
      abort_pulse_q <= busy && (state_d == ST_ABORT);
    end
  end

  assign abort_pulse = abort_pulse_q;
`else
  assign wdt_expire  = 1'b0;
  assign abort_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2_wdt.sv
module tb_wb_arbiter_2_wdt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] m0_adr, m0_dat_w, m1_adr, m1_dat_w;
  logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] s_dat_r;
  logic        s_ack, s_err, s_rty;

  logic [31:0] m0_dat_r, m1_dat_r, s_adr, s_dat_w;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_we, s_stb, s_cyc, timeout;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  logic [31:0] fx_m0_dat_r, fx_m1_dat_r, fx_s_adr, fx_s_dat_w;
  logic        fx_m0_ack, fx_m0_err, fx_m0_rty, fx_m1_ack, fx_m1_err, fx_m1_rty;
  logic        fx_s_we, fx_s_stb, fx_s_cyc, fx_timeout;
  logic [3:0]  fx_s_sel;
  logic [1:0]  fx_grant;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          kind;   // 0 ack, 1 err, 2 rty
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  // Round-robin arbiter; preferred master 0; watchdog limit 8.
  wb_arbiter_2_wdt #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
    .ARB_TYPE_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat_w), .wbm0_dat_o(m0_dat_r), .wbm0_we_i(m0_we),
    .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err),
    .wbm0_rty_o(m0_rty), .wbm0_cyc_i(m0_cyc),
    .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat_w), .wbm1_dat_o(m1_dat_r), .wbm1_we_i(m1_we),
    .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err),
    .wbm1_rty_o(m1_rty), .wbm1_cyc_i(m1_cyc),
    .wbs_adr_o(s_adr), .wbs_dat_i(s_dat_r), .wbs_dat_o(s_dat_w), .wbs_we_o(s_we),
    .wbs_sel_o(s_sel), .wbs_stb_o(s_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .wbs_rty_i(s_rty), .wbs_cyc_o(s_cyc),
    .grant_o(grant), .timeout_o(timeout)
  );

  // Fixed-priority arbiter where master 1 wins ties; it shares all inputs.
  wb_arbiter_2_wdt #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
    .ARB_TYPE_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(0), .TIMEOUT(8)
  ) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat_w), .wbm0_dat_o(fx_m0_dat_r), .wbm0_we_i(m0_we),
    .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb), .wbm0_ack_o(fx_m0_ack), .wbm0_err_o(fx_m0_err),
    .wbm0_rty_o(fx_m0_rty), .wbm0_cyc_i(m0_cyc),
    .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat_w), .wbm1_dat_o(fx_m1_dat_r), .wbm1_we_i(m1_we),
    .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb), .wbm1_ack_o(fx_m1_ack), .wbm1_err_o(fx_m1_err),
    .wbm1_rty_o(fx_m1_rty), .wbm1_cyc_i(m1_cyc),
    .wbs_adr_o(fx_s_adr), .wbs_dat_i(s_dat_r), .wbs_dat_o(fx_s_dat_w), .wbs_we_o(fx_s_we),
    .wbs_sel_o(fx_s_sel), .wbs_stb_o(fx_s_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
    .wbs_rty_i(s_rty), .wbs_cyc_o(fx_s_cyc),
    .grant_o(fx_grant), .timeout_o(fx_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [5:0] resp_vec();
    return {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty};
  endfunction

  task automatic drive_m(input int m, input logic [31:0] adr, input logic [31:0] dat,
                         input logic we, input logic stb);
    if (m == 0) begin
      m0_adr = adr; m0_dat_w = dat; m0_we = we; m0_sel = 4'hF; m0_stb = stb;
    end else begin
      m1_adr = adr; m1_dat_w = dat; m1_we = we; m1_sel = 4'hF; m1_stb = stb;
    end
  endtask

  // Called just after a rising edge. It raises STB for master m, records the
  // expectation, then acts as the slave once the request shows up on the
  // slave port.
  task automatic xfer(input int m, input logic [31:0] adr, input logic [31:0] dat,
                      input logic we, input int lat, input int kind, input logic [31:0] rdata);
    exp_t e;
    exp_t got_e;
    int   n;
    logic [2:0] r3;
    e.m = m; e.adr = adr; e.dat = dat; e.we = we; e.kind = kind; e.rdata = rdata;
    sb.push_back(e);
    drive_m(m, adr, dat, we, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_cyc && s_stb) && n < 20);
    got_e = sb.pop_front();
    if (!(s_cyc && s_stb)) begin
      check("xfer_wait", 0, 1);
      @(posedge clk); #1;
      drive_m(m, adr, dat, we, 1'b0);
      return;
    end
    check("xfer_grant", grant, onehot(got_e.m));
    check("xfer_adr", s_adr, got_e.adr);
    check("xfer_we", s_we, got_e.we);
    if (got_e.we) check("xfer_wdat", s_dat_w, got_e.dat);
    repeat (lat) @(negedge clk);
    s_dat_r = got_e.rdata;
    s_ack = (got_e.kind == 0);
    s_err = (got_e.kind == 1);
    s_rty = (got_e.kind == 2);
    #1;
    r3 = (got_e.kind == 0) ? 3'b100 : (got_e.kind == 1) ? 3'b010 : 3'b001;
    check("xfer_route", resp_vec(), (got_e.m == 0) ? {r3, 3'b000} : {3'b000, r3});
    if (!got_e.we && got_e.kind == 0)
      check("xfer_rdat", (got_e.m == 0) ? m0_dat_r : m1_dat_r, got_e.rdata);
    @(posedge clk); #1;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    drive_m(m, adr, dat, we, 1'b0);
  endtask

  initial begin : stim
    int   n;
    int   exp_m;
    logic bad;

    rst_n = 1'b0;
    m0_adr = 32'hDEAD_0000; m0_dat_w = '0; m0_we = 1'b0; m0_sel = '0; m0_stb = 1'b0;
    m1_adr = 32'h0000_0200; m1_dat_w = '0; m1_we = 1'b0; m1_sel = '0; m1_stb = 1'b0;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    // Reset held for two edges while both masters request.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_cyc", {s_cyc, s_stb}, 2'b00);
    check("rst_adr", s_adr, 32'h0);
    check("rst_resp", resp_vec(), 6'b0);
    check("rst_timeout", timeout, 1'b0);
    check("fx_rst_grant", fx_grant, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arb_latency", grant, 2'b00);
    @(negedge clk);
    check("first_grant", grant, 2'b01);
    check("first_cyc", s_cyc, 1'b1);
    check("first_adr", s_adr, 32'hDEAD_0000);
    check("fx_first_grant", fx_grant, 2'b10);
    @(posedge clk); #1;

    // Three writes from master 0, then master 0 releases the bus.
    xfer(0, 32'h10, 32'h1111_0001, 1'b1, 0, 0, 32'h0);
    xfer(0, 32'h14, 32'h1111_0002, 1'b1, 0, 0, 32'h0);
    xfer(0, 32'h18, 32'h1111_0003, 1'b1, 1, 0, 32'h0);
    m0_cyc = 1'b0;
    @(negedge clk);
    check("drop_still_busy", grant, 2'b01);
    @(negedge clk);
    check("dead_cyc", s_cyc, 1'b0);
    check("dead_grant", grant, 2'b00);
    @(negedge clk);
    check("m1_grant", grant, 2'b10);
    check("m1_adr", s_adr, 32'h200);
    @(posedge clk); #1;

    // Master 1: read with latency, then err and rty terminations.
    xfer(1, 32'h204, 32'h0, 1'b0, 2, 0, 32'hCAFE_F00D);
    xfer(1, 32'h208, 32'h55, 1'b1, 1, 1, 32'h0);
    xfer(1, 32'h20C, 32'h66, 1'b1, 0, 2, 32'h0);

    // Round robin: both masters keep requesting; each holds 4 cycles.
    m0_cyc = 1'b1;
    m1_cyc = 1'b0;
    @(posedge clk); #1;
    m1_cyc = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_m = r % 2;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (grant == 2'b00 && n < 4);
      check("rr_grant", grant, onehot(exp_m));
      if (r == 0) check("fx_fixed_grant", fx_grant, 2'b10);
      repeat (3) begin
        @(negedge clk);
        check("rr_hold", grant, onehot(exp_m));
      end
      @(posedge clk); #1;
      if (exp_m == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      @(posedge clk); #1;
      if (exp_m == 0) m0_cyc = 1'b1; else m1_cyc = 1'b1;
    end
    m1_cyc = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant != 2'b01 && n < 6);
    check("m0_regrant", grant, 2'b01);
    @(posedge clk); #1;

`ifdef WB_ARB_WATCHDOG_EN
    // Slave never answers: abort on the 8th cycle after STB.
    m1_cyc = 1'b1;
    drive_m(0, 32'h40, 32'h0, 1'b1, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m0_err || timeout || !s_cyc) bad = 1'b1;
    end
    @(negedge clk);
    check("wdt_early", bad, 1'b0);
    check("wdt_err", {m0_err, m1_err}, 2'b10);
    check("wdt_timeout", timeout, 1'b1);
    check("wdt_cyc", s_cyc, 1'b0);
    check("wdt_grant", grant, 2'b00);
    @(negedge clk);
    check("abort_hold", {m0_err, timeout, s_cyc}, 3'b000);
    @(posedge clk); #1;
    m0_cyc = 1'b0;
    m0_stb = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant != 2'b10 && n < 5);
    check("wdt_next_grant", grant, 2'b10);
    @(posedge clk); #1;

    // Slave acks exactly on the expiry cycle: the ack wins.
    drive_m(1, 32'h240, 32'h77, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) @(negedge clk);
    s_ack = 1'b1;
    #1;
    check("race_ack", {m1_ack, m1_err}, 2'b10);
    @(posedge clk); #1;
    s_ack = 1'b0;
    m1_stb = 1'b0;
    @(negedge clk);
    check("race_no_abort", {timeout, m1_err}, 2'b00);
    check("race_grant", grant, 2'b10);
    @(posedge clk); #1;
    m1_stb = 1'b1;
`else
    // No watchdog: a stalled slave keeps the grant indefinitely.
    drive_m(0, 32'h40, 32'h0, 1'b1, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m0_err || timeout || grant != 2'b01) bad = 1'b1;
    end
    check("stall_no_abort", bad, 1'b0);
    check("stall_grant", grant, 2'b01);
    check("stall_cyc", {s_cyc, s_stb}, 2'b11);
    @(posedge clk); #1;
`endif

    // Reset while an access is pending: dropped silently.
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_grant", grant, 2'b00);
    check("midrst_slave", {s_cyc, s_stb, s_we}, 3'b000);
    check("midrst_adr", s_adr, 32'h0);
    check("midrst_resp", resp_vec(), 6'b0);
    check("midrst_timeout", timeout, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
